// File: rtl/prog_loader_pkg.sv
// Shared types and constants for the program loader.
// States, stream word width and ROM capacity helper.
package prog_loader_pkg;

  localparam int WORD_W = 16;

  typedef enum logic [2:0] {
    IDLE,
    LEN,
    DATA,
    CSUM,
    DONE,
    ERR
  } state_e;

  function automatic int max_words(input int rom_size);
    return 1 << rom_size;
  endfunction

endpackage

// File: rtl/ld_frame_acc.sv
// Frame accumulator: word count, ROM address and running checksum.
// count_done flags that the current step is the last program word.
module ld_frame_acc
  import prog_loader_pkg::*;
#(
  parameter int ROM_SIZE = 8
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                clear,
  input  logic                step,
  input  logic [WORD_W-1:0]   word,
  input  logic [ROM_SIZE:0]   n,
  output logic                count_done,
  output logic [WORD_W-1:0]   sum,
  output logic [ROM_SIZE-1:0] addr
);

  logic [ROM_SIZE:0]   count_q, count_d;
  logic [WORD_W-1:0]   sum_q, sum_d;
  logic [ROM_SIZE-1:0] addr_q, addr_d;

  always_comb begin
    count_d = count_q;
    sum_d   = sum_q;
    addr_d  = addr_q;
    if (clear) begin
      count_d = '0;
      sum_d   = '0;
      addr_d  = '0;
    end else if (step) begin
      count_d = count_q + 1'b1;
      sum_d   = sum_q + word;
      addr_d  = addr_q + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_q <= '0;
      sum_q   <= '0;
      addr_q  <= '0;
    end else begin
      count_q <= count_d;
      sum_q   <= sum_d;
      addr_q  <= addr_d;
    end
  end

  // count is one bit wider than addr so N = 2^ROM_SIZE still compares.
  assign count_done = (count_q + 1'b1) == n;
  assign sum        = sum_q;
  assign addr       = addr_q;

endmodule

// File: rtl/prog_loader.sv
// Instruction ROM loader: framed stream in, ROM writes out.
// Keeps the core in reset until a checksum-verified image is in place.
module prog_loader
  import prog_loader_pkg::*;
#(
  parameter int ROM_SIZE = 8
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  input  logic                in_valid,
  input  logic [15:0]         in_data,
  output logic                in_ready,
  output logic                rom_we,
  output logic [ROM_SIZE-1:0] rom_waddr,
  output logic [15:0]         rom_wdata,
  output logic                core_rst,
  output logic                busy,
  output logic                done,
  output logic                error
);

  localparam logic [WORD_W:0] MAXW = (WORD_W+1)'(max_words(ROM_SIZE));

  state_e state_q, state_d;

  logic [ROM_SIZE:0]   n_q, n_d;
  logic                we_q, we_d;
  logic [ROM_SIZE-1:0] waddr_q, waddr_d;
  logic [WORD_W-1:0]   wdata_q, wdata_d;

  logic                xfer;
  logic                len_bad;
  logic                acc_clear;
  logic                acc_step;
  logic                count_done;
  logic [WORD_W-1:0]   sum;
  logic [ROM_SIZE-1:0] addr;

  ld_frame_acc #(.ROM_SIZE(ROM_SIZE)) u_acc (
    .clk        (clk),
    .rst        (rst),
    .clear      (acc_clear),
    .step       (acc_step),
    .word       (in_data),
    .n          (n_q),
    .count_done (count_done),
    .sum        (sum),
    .addr       (addr)
  );

  assign xfer    = in_valid && in_ready;
  assign len_bad = (in_data == '0) || ({1'b0, in_data} > MAXW);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      n_q     <= '0;
      we_q    <= 1'b0;
      waddr_q <= '0;
      wdata_q <= '0;
    end else begin
      state_q <= state_d;
      n_q     <= n_d;
      we_q    <= we_d;
      waddr_q <= waddr_d;
      wdata_q <= wdata_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    n_d       = n_q;
    we_d      = 1'b0;
    waddr_d   = waddr_q;
    wdata_d   = wdata_q;
    acc_clear = 1'b0;
    acc_step  = 1'b0;
    unique case (state_q)
      IDLE, DONE, ERR: begin
        if (start) begin
          state_d   = LEN;
          acc_clear = 1'b1;
        end
      end
      LEN: begin
        if (xfer) begin
          if (len_bad) begin
            state_d = ERR;
          end else begin
            n_d     = in_data[ROM_SIZE:0];
            state_d = DATA;
          end
        end
      end
      DATA: begin
        if (xfer) begin
          acc_step = 1'b1;
          we_d     = 1'b1;
          waddr_d  = addr;
          wdata_d  = in_data;
          if (count_done) state_d = CSUM;
        end
      end
      CSUM: begin
        if (xfer) state_d = (in_data == sum) ? DONE : ERR;
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    in_ready = 1'b0;
    busy     = 1'b0;
    done     = 1'b0;
    error    = 1'b0;
    core_rst = 1'b1;
    unique case (state_q)
      LEN, DATA, CSUM: begin
        in_ready = 1'b1;
        busy     = 1'b1;
      end
      DONE: begin
        done     = 1'b1;
        core_rst = 1'b0;
      end
      ERR:     error = 1'b1;
      default: ;
    endcase
  end

  assign rom_we    = we_q;
  assign rom_waddr = waddr_q;
  assign rom_wdata = wdata_q;

endmodule

// File: doc/prog_loader.md
Name: prog_loader

Overview:
- Writer side of the instruction-memory interface: receives a framed program stream over a valid/ready word channel and writes it into the instruction ROM through a write port.
- Holds the processor core in reset until a complete, checksum-verified image has been written.
- Sits beside the ROM in the processor top. It drives the ROM write port and the core reset input; the control unit remains the ROM reader.

Parameters:
- ROM_SIZE, 8, instruction-memory address width; capacity is 2^ROM_SIZE words.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  asynchronous, active-high reset.
- start  input  1  one-cycle pulse that begins a load; honoured only in IDLE, DONE or ERR.
- in_valid  input  1  stream word present.
- in_data  input  16  stream word.
- in_ready  output  1  loader accepts a word this cycle.
- rom_we  output  1  ROM write strobe.
- rom_waddr  output  ROM_SIZE  ROM write address.
- rom_wdata  output  16  ROM write data.
- core_rst  output  1  holds the processor core (control unit) in reset.
- busy  output  1  load in progress (LEN, DATA or CSUM).
- done  output  1  image loaded and verified.
- error  output  1  framing or checksum failure.

Behaviour:
- Reset (async) values:
  - state=IDLE, core_rst=1.
  - in_ready, rom_we, busy, done, error = 0.
  - rom_waddr=0, rom_wdata=0.
  - Internal count=0, sum=0.
- Transfer rule: a word transfers only on a rising edge with in_valid && in_ready.
- in_ready: equals 1 exactly when state is LEN, DATA or CSUM (combinational from state). in_data is ignored in every other state.
- Frame format: length word N, then N program words, then one checksum word.
- Checksum: the 16-bit sum modulo 2^16 of the N program words only. The length word is excluded.
- FSM states:
  - IDLE: on start -> LEN; clear count, sum and address.
  - LEN: on transfer, latch N.
    - N==0 or N > 2^ROM_SIZE -> ERR.
    - Otherwise -> DATA.
    - count is ROM_SIZE+1 bits, so N=2^ROM_SIZE is legal.
  - DATA: on each transfer:
    - Register the word into rom_wdata and the current address into rom_waddr.
    - Pulse rom_we high the next cycle. Write latency is 1 cycle after the transfer edge.
    - sum += word (wraps mod 2^16). Address increments. count increments.
    - When count reaches N -> CSUM.
    - Address wraps to 0 only after the final word at 2^ROM_SIZE-1; that wrap is never used for a write.
  - CSUM: on transfer, word==sum -> DONE, otherwise -> ERR. The final rom_we pulse overlaps the first CSUM cycle, which is legal.
  - DONE: done=1, core_rst=0. On start -> LEN, with core_rst=1 the same cycle the state changes.
  - ERR: error=1, core_rst=1. On start -> LEN; error clears.
- busy: 1 in LEN, DATA and CSUM.
- core_rst: 1 in every state except DONE. A partially written image never runs.
- start while busy: ignored. No restart and no effect on the ongoing load.
- start coinciding with a transfer in LEN/DATA/CSUM: the transfer proceeds normally.
- in_valid may deassert at any time. Stalls are unbounded and there is no timeout.
- rst asserted mid-load: immediate return to IDLE with core_rst=1. ROM contents are left as-is; no rollback.
- rom_we is never asserted outside the cycle following a DATA transfer.

Decomposition:
- Shared package prog_loader_pkg holds:
  - state enum (IDLE, LEN, DATA, CSUM, DONE, ERR);
  - constant WORD_W=16;
  - helper function max_words(ROM_SIZE) = 2^ROM_SIZE.
- One natural sub-module, ld_frame_acc: the count/address/sum accumulator with clear and step inputs. It exposes count_done and sum.
- The FSM and the ROM write register stay in prog_loader.

Test Plan:
- Basic load: reset, start, stream N=3, words 0x1111, 0x2222, 0x3333, checksum 0x6666 with in_valid held high -> rom_we pulses at addresses 0,1,2 with those data, each 1 cycle after its transfer; done=1; core_rst falls in the DONE cycle.
- Bad checksum: same frame with checksum 0x6667 -> all three words written, error=1, core_rst stays 1, done=0.
- Length bounds, ROM_SIZE=8:
  - N=0 -> ERR with no rom_we.
  - N=257 -> ERR with no rom_we.
  - N=256 with words 0..255 and checksum 0x7F80 -> 256 writes, last to address 0xFF, then DONE.
- Backpressure/stalls: random in_valid gaps during N=4, words 0xFFFF x4, checksum 0xFFFC (wrapping sum) -> identical writes and DONE; no write occurs on cycles without a transfer.
- Start while busy and reload:
  - A start pulse mid-DATA is ignored and the load completes.
  - A start in DONE -> core_rst returns to 1 immediately; a second image N=1, word 0xABCD, checksum 0xABCD overwrites address 0 -> DONE.
- Async reset mid-DATA: assert rst between clock edges after 2 of 5 words -> outputs return to reset values immediately, state IDLE; a subsequent start with a fresh frame loads correctly from address 0.
